codec_spi_writer: RTL and testbench

Write-only SPI master sitting directly downstream of the codec configuration sequencer. It accepts one control word per trigger/ready handshake and serialises it MSB-first to the audio codec's 3-wire control port. The block owns SCK, MOSI and the frame-select line, including setup, hold and inter-word gap timing, and pulses a completion strobe after each word.

---
 rtl/codec_spi_writer.sv | 145 ++++++++++++++
 tb/tb_codec_spi_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_spi_writer.sv
// Write-only 3-wire SPI master for codec control words: MSB first, CPOL=0,
// with cs_n setup/hold/gap timing and a one-cycle done strobe per word.
module codec_spi_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  trg,
  output logic                  rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  mosi,
  output logic                  sck,
  output logic                  cs_n
);
  localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                             : ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int TW  = $clog2(TMAX + 1);
  localparam int DVW = $clog2(2 * CLK_DIV);
  localparam int BW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [TW-1:0]  SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0]  HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0]  GAP_LAST   = TW'(CS_GAP - 1);
  localparam logic [DVW-1:0] DIV_LAST   = DVW'(2 * CLK_DIV - 1);
  localparam logic [DVW-1:0] DIV_HIGH   = DVW'(CLK_DIV);
  localparam logic [BW-1:0]  BIT_TOP    = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state, state_nx;
  logic [TW-1:0]         tmr, tmr_nx;
  logic [DVW-1:0]        div, div_nx;
  logic [BW-1:0]         bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] shreg, sh_nx;
  logic                  rdy_nx, done_nx, mosi_nx, sck_nx, cs_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmr     <= '0;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rdy     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      mosi    <= 1'b0;
      sck     <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_nx;
      tmr     <= tmr_nx;
      div     <= div_nx;
      bit_cnt <= bit_nx;
      shreg   <= sh_nx;
      rdy     <= rdy_nx;
      busy    <= ~rdy_nx;
      done    <= done_nx;
      mosi    <= mosi_nx;
      sck     <= sck_nx;
      cs_n    <= cs_nx;
    end
  end

  // Outputs are computed as next-values here so every port comes straight off a flop.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    div_nx   = div;
    bit_nx   = bit_cnt;
    sh_nx    = shreg;
    rdy_nx   = 1'b0;
    done_nx  = 1'b0;
    mosi_nx  = mosi;
    sck_nx   = 1'b0;
    cs_nx    = cs_n;
    case (state)
      IDLE: begin
        rdy_nx  = 1'b1;
        cs_nx   = 1'b1;
        mosi_nx = 1'b0;
        if (trg && rdy) begin
          state_nx = SETUP;
          tmr_nx   = '0;
          sh_nx    = data;
          mosi_nx  = data[DATA_WIDTH-1];
          cs_nx    = 1'b0;
          rdy_nx   = 1'b0;
        end
      end
      SETUP: begin
        if (tmr == SETUP_LAST) begin
          state_nx = SHIFT;
          div_nx   = '0;
          bit_nx   = BIT_TOP;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          div_nx = '0;
          if (bit_cnt == '0) begin
            state_nx = HOLD;
            tmr_nx   = '0;
          end else begin
            // New bit goes out on the falling edge so it is stable across the next rise.
            bit_nx  = bit_cnt - BW'(1);
            sh_nx   = shreg << 1;
            mosi_nx = shreg[DATA_WIDTH-2];
          end
        end else begin
          div_nx = div + DVW'(1);
          sck_nx = (div_nx >= DIV_HIGH);
        end
      end
      HOLD: begin
        if (tmr == HOLD_LAST) begin
          state_nx = GAP;
          tmr_nx   = '0;
          cs_nx    = 1'b1;
          mosi_nx  = 1'b0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      GAP: begin
        if (tmr == GAP_LAST) begin
          state_nx = IDLE;
          rdy_nx   = 1'b1;
          done_nx  = 1'b1;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_codec_spi_writer.sv
// Directed bench for codec_spi_writer: default 16-bit instance plus a 24-bit,
// CLK_DIV=1 instance; a negedge monitor decodes frames and watches SPI invariants.
module tb_codec_spi_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] data_a;
  logic        trg_a, rdy_a, busy_a, done_a, mosi_a, sck_a, cs_n_a;
  logic [23:0] data_b;
  logic        trg_b, rdy_b, busy_b, done_b, mosi_b, sck_b, cs_n_b;

  int errors = 0;
  int checks = 0;

  codec_spi_writer dut_a (
    .clk(clk), .reset(reset), .data(data_a), .trg(trg_a), .rdy(rdy_a), .busy(busy_a),
    .done(done_a), .mosi(mosi_a), .sck(sck_a), .cs_n(cs_n_a));

  codec_spi_writer #(.DATA_WIDTH(24), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .trg(trg_b), .rdy(rdy_b), .busy(busy_b),
    .done(done_b), .mosi(mosi_b), .sck(sck_b), .cs_n(cs_n_b));

  // ---- frame monitor, instance A ----
  logic [31:0] fa_word[$];
  int          fa_bits[$], fa_low[$], fa_gap[$];
  logic        pcs_a = 1'b1, psck_a = 1'b0, pmosi_a = 1'b0;
  logic [31:0] wa = '0;
  int          ba = 0, la = 0, hi_a = 0, dcnt_a = 0, viol_a = 0;

  always @(negedge clk) begin
    if (cs_n_a === 1'b0 && pcs_a === 1'b1) begin
      fa_gap.push_back(hi_a); wa = '0; ba = 0; la = 0; hi_a = 0;
    end
    if (cs_n_a === 1'b0) begin
      la++;
      if (sck_a === 1'b1 && psck_a === 1'b0) begin wa = {wa[30:0], mosi_a}; ba++; end
    end else hi_a++;
    if (cs_n_a === 1'b1 && pcs_a === 1'b0) begin
      fa_word.push_back(wa); fa_bits.push_back(ba); fa_low.push_back(la);
    end
    if (done_a === 1'b1) dcnt_a++;
    if (sck_a === 1'b1 && mosi_a !== pmosi_a) viol_a++;
    if (sck_a === 1'b1 && cs_n_a === 1'b1) viol_a++;
    pcs_a = cs_n_a; psck_a = sck_a; pmosi_a = mosi_a;
  end

  // ---- frame monitor, instance B (also checks the sck period) ----
  logic [31:0] fb_word[$];
  int          fb_bits[$];
  logic        pcs_b = 1'b1, psck_b = 1'b0, pmosi_b = 1'b0;
  logic [31:0] wb = '0;
  int          bb = 0, cyc_b = 0, last_rise_b = -1, per_bad_b = 0, dcnt_b = 0, viol_b = 0;

  always @(negedge clk) begin
    cyc_b++;
    if (cs_n_b === 1'b0 && pcs_b === 1'b1) begin wb = '0; bb = 0; last_rise_b = -1; end
    if (cs_n_b === 1'b0 && sck_b === 1'b1 && psck_b === 1'b0) begin
      wb = {wb[30:0], mosi_b}; bb++;
      if (last_rise_b >= 0 && cyc_b - last_rise_b != 2) per_bad_b++;
      last_rise_b = cyc_b;
    end
    if (cs_n_b === 1'b1 && pcs_b === 1'b0) begin fb_word.push_back(wb); fb_bits.push_back(bb); end
    if (done_b === 1'b1) dcnt_b++;
    if (sck_b === 1'b1 && mosi_b !== pmosi_b) viol_b++;
    if (sck_b === 1'b1 && cs_n_b === 1'b1) viol_b++;
    pcs_b = cs_n_b; psck_b = sck_b; pmosi_b = mosi_b;
  end

  task automatic test_reset();
    reset = 1'b1; trg_a = 1'b0; data_a = '0; trg_b = 1'b0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL reset_rdy_busy: got rdy=%b busy=%b want 1 0", rdy_a, busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (cs_n_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0) begin errors++; $display("FAIL reset_pins: got cs_n=%b sck=%b mosi=%b want 1 0 0", cs_n_a, sck_a, mosi_a); end
    checks++; if (rdy_b !== 1'b1 || cs_n_b !== 1'b1) begin errors++; $display("FAIL reset_b: got rdy=%b cs_n=%b want 1 1", rdy_b, cs_n_b); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b1 || cs_n_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got rdy=%b cs_n=%b done=%b want 1 1 0", rdy_a, cs_n_a, done_a); end
  endtask

  task automatic test_single();
    int k = 0;
    int n0 = dcnt_a;
    int f0 = fa_word.size();
    @(negedge clk); data_a = 16'h1E00; trg_a = 1'b1;
    @(posedge clk); #1 trg_a = 1'b0;
    checks++; if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL single_accept: got rdy=%b busy=%b want 0 1", rdy_a, busy_a); end
    while (done_a !== 1'b1 && k < 300) begin @(posedge clk); #1 k++; end
    checks++; if (k !== 136) begin errors++; $display("FAIL single_done_latency: got %0d want 136", k); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL single_rdy_at_done: got %b want 1", rdy_a); end
    @(posedge clk); #1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done_a); end
    checks++; if (dcnt_a - n0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", dcnt_a - n0); end
    checks++;
    if (fa_word.size() !== f0 + 1) begin errors++; $display("FAIL single_frames: got %0d want %0d", fa_word.size(), f0 + 1); end
    else begin
      checks++; if (fa_word[f0] !== 32'h1E00) begin errors++; $display("FAIL single_word: got %h want 1e00", fa_word[f0]); end
      checks++; if (fa_bits[f0] !== 16) begin errors++; $display("FAIL single_bits: got %0d want 16", fa_bits[f0]); end
      checks++; if (fa_low[f0] !== 132) begin errors++; $display("FAIL single_cs_low: got %0d want 132", fa_low[f0]); end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int n0 = dcnt_a;
    int f0 = fa_word.size();
    @(negedge clk); data_a = 16'h0C10; trg_a = 1'b1;
    @(posedge clk); #1 data_a = 16'h0E53;
    while (done_a !== 1'b1 && k < 300) begin @(posedge clk); #1 k++; end
    checks++; if (k !== 136) begin errors++; $display("FAIL b2b_first_latency: got %0d want 136", k); end
    @(posedge clk); #1 trg_a = 1'b0;
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got rdy=%b want 0", rdy_a); end
    k = 0;
    while (done_a !== 1'b1 && k < 300) begin @(posedge clk); #1 k++; end
    checks++; if (k !== 136) begin errors++; $display("FAIL b2b_second_latency: got %0d want 136", k); end
    @(posedge clk); #1;
    checks++; if (dcnt_a - n0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dcnt_a - n0); end
    checks++;
    if (fa_word.size() !== f0 + 2) begin errors++; $display("FAIL b2b_frames: got %0d want %0d", fa_word.size(), f0 + 2); end
    else begin
      checks++; if (fa_word[f0] !== 32'h0C10 || fa_bits[f0] !== 16) begin errors++; $display("FAIL b2b_word0: got %h/%0d want 0c10/16", fa_word[f0], fa_bits[f0]); end
      checks++; if (fa_word[f0+1] !== 32'h0E53 || fa_bits[f0+1] !== 16) begin errors++; $display("FAIL b2b_word1: got %h/%0d want 0e53/16", fa_word[f0+1], fa_bits[f0+1]); end
      checks++; if (fa_gap[f0+1] !== 5) begin errors++; $display("FAIL b2b_cs_gap: got %0d want 5", fa_gap[f0+1]); end
    end
  endtask

  task automatic test_ignore_busy_trg();
    int k = 0;
    int n0 = dcnt_a;
    int f0 = fa_word.size();
    @(negedge clk); data_a = 16'h0123; trg_a = 1'b1;
    @(posedge clk); #1 trg_a = 1'b0; data_a = '0;
    while (done_a !== 1'b1 && k < 300) begin
      @(posedge clk); #1 k++;
      if (k == 40) begin trg_a = 1'b1; data_a = 16'hFFFF; end
      else if (k == 41) begin trg_a = 1'b0; data_a = '0; end
    end
    checks++; if (k !== 136) begin errors++; $display("FAIL ignore_latency: got %0d want 136", k); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (cs_n_a !== 1'b1 || rdy_a !== 1'b1) begin errors++; $display("FAIL ignore_idle: got cs_n=%b rdy=%b want 1 1", cs_n_a, rdy_a); end
    checks++; if (dcnt_a - n0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dcnt_a - n0); end
    checks++;
    if (fa_word.size() !== f0 + 1) begin errors++; $display("FAIL ignore_frames: got %0d want %0d", fa_word.size(), f0 + 1); end
    else begin
      checks++; if (fa_word[f0] !== 32'h0123) begin errors++; $display("FAIL ignore_word: got %h want 0123", fa_word[f0]); end
    end
  endtask

  task automatic test_reset_mid_word();
    int k = 0;
    int rises = 0;
    logic ps = 1'b0;
    int n0 = dcnt_a;
    int f0 = fa_word.size();
    @(negedge clk); data_a = 16'hF0F0; trg_a = 1'b1;
    @(posedge clk); #1 trg_a = 1'b0;
    while (rises < 8 && k < 300) begin
      @(posedge clk); #1 k++;
      if (sck_a === 1'b1 && ps === 1'b0) rises++;
      ps = sck_a;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs_n_a !== 1'b1 || sck_a !== 1'b0) begin errors++; $display("FAIL midrst_pins: got cs_n=%b sck=%b want 1 0", cs_n_a, sck_a); end
    checks++; if (rdy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL midrst_status: got rdy=%b done=%b want 1 0", rdy_a, done_a); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (dcnt_a !== n0) begin errors++; $display("FAIL midrst_no_done: got %0d want %0d", dcnt_a, n0); end
    checks++;
    if (fa_bits.size() !== f0 + 1) begin errors++; $display("FAIL midrst_partial: got %0d frames want %0d", fa_bits.size(), f0 + 1); end
    else begin
      checks++; if (fa_bits[f0] !== 8) begin errors++; $display("FAIL midrst_partial_bits: got %0d want 8", fa_bits[f0]); end
    end
    f0 = fa_word.size();
    @(negedge clk); data_a = 16'h1201; trg_a = 1'b1;
    @(posedge clk); #1 trg_a = 1'b0;
    k = 0;
    while (done_a !== 1'b1 && k < 300) begin @(posedge clk); #1 k++; end
    checks++; if (k !== 136) begin errors++; $display("FAIL midrst_next_latency: got %0d want 136", k); end
    @(posedge clk); #1;
    checks++;
    if (fa_word.size() !== f0 + 1) begin errors++; $display("FAIL midrst_next_frames: got %0d want %0d", fa_word.size(), f0 + 1); end
    else begin
      checks++; if (fa_word[f0] !== 32'h1201 || fa_bits[f0] !== 16) begin errors++; $display("FAIL midrst_next_word: got %h/%0d want 1201/16", fa_word[f0], fa_bits[f0]); end
    end
  endtask

  task automatic test_wide_fast();
    int k = 0;
    int n0 = dcnt_b;
    int f0 = fb_word.size();
    @(negedge clk); data_b = 24'hA5C33C; trg_b = 1'b1;
    @(posedge clk); #1 trg_b = 1'b0; data_b = '0;
    while (rdy_b !== 1'b1 && k < 200) begin @(posedge clk); #1 k++; end
    checks++; if (k !== 56) begin errors++; $display("FAIL wide_rdy_low: got %0d want 56", k); end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL wide_done_with_rdy: got %b want 1", done_b); end
    @(posedge clk); #1;
    checks++; if (dcnt_b - n0 !== 1) begin errors++; $display("FAIL wide_done_count: got %0d want 1", dcnt_b - n0); end
    checks++; if (per_bad_b !== 0) begin errors++; $display("FAIL wide_sck_period: got %0d bad periods want 0", per_bad_b); end
    checks++;
    if (fb_word.size() !== f0 + 1) begin errors++; $display("FAIL wide_frames: got %0d want %0d", fb_word.size(), f0 + 1); end
    else begin
      checks++; if (fb_word[f0] !== 32'h00A5C33C) begin errors++; $display("FAIL wide_word: got %h want a5c33c", fb_word[f0]); end
      checks++; if (fb_bits[f0] !== 24) begin errors++; $display("FAIL wide_bits: got %0d want 24", fb_bits[f0]); end
    end
  endtask

  task automatic test_invariants();
    checks++; if (viol_a !== 0) begin errors++; $display("FAIL invariants_a: got %0d violations want 0", viol_a); end
    checks++; if (viol_b !== 0) begin errors++; $display("FAIL invariants_b: got %0d violations want 0", viol_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy_trg();
    test_reset_mid_word();
    test_wide_fast();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
